enc_word_framer: RTL

Upstream feeder for the 7-to-4 encoder stage. Collects a serial bit stream into WIDTH-bit words, MSB first. Each frame is delimited by a start-of-frame strobe. Completed words are buffered in a small FIFO and presented through a valid/ready handshake; word_out drives the encoder's 7-bit input directly.

---
 rtl/enc_word_framer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/enc_word_framer.sv
// Serial-to-word framer: assembles sof-delimited WIDTH-bit frames (MSB first)
// and buffers completed words in a small FIFO behind a valid/ready handshake.
module enc_word_framer #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             overflow,
  output logic             sync_err
);

  localparam int unsigned BCW = $clog2(WIDTH + 1);
  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCW = $clog2(DEPTH + 1);

  typedef enum logic {HUNT, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [BCW-1:0]   bcnt_q, bcnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_word_q, pend_word_d;
  logic             sync_err_q, sync_err_d;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OCW-1:0]   occ_q, occ_d;
  logic [WIDTH-1:0] word_out_q, word_out_d;
  logic             word_valid_q, word_valid_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             overflow_q, overflow_d;
  logic             pop, full, push_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Frame assembly; a completed word is staged for one cycle before the push.
  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    shreg_d     = shreg_q;
    pend_d      = 1'b0;
    pend_word_d = pend_word_q;
    sync_err_d  = 1'b0;
    case (state_q)
      HUNT: begin
        if (bit_valid && sof) begin
          shreg_d = WIDTH'(bit_in);
          bcnt_d  = BCW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          if (sof) begin
            sync_err_d = 1'b1;
            shreg_d    = WIDTH'(bit_in);
            bcnt_d     = BCW'(1);
          end else if (bcnt_q == BCW'(WIDTH - 1)) begin
            pend_d      = 1'b1;
            pend_word_d = {shreg_q[WIDTH-2:0], bit_in};
            shreg_d     = {shreg_q[WIDTH-2:0], bit_in};
            bcnt_d      = '0;
            state_d     = HUNT;
          end else begin
            shreg_d = {shreg_q[WIDTH-2:0], bit_in};
            bcnt_d  = bcnt_q + BCW'(1);
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // FIFO; a pop in the same cycle frees the slot for a push into a full FIFO.
  always_comb begin
    pop         = word_valid_q && word_ready;
    full        = (occ_q == OCW'(DEPTH));
    push_ok     = pend_q && (!full || pop);
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    frame_cnt_d = frame_cnt_q;
    overflow_d  = overflow_q | (pend_q & ~push_ok);
    if (push_ok) begin
      mem_d[wr_ptr_q] = pend_word_q;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
      frame_cnt_d     = frame_cnt_q + CNT_W'(1);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_ok, pop})
      2'b10:   occ_d = occ_q + OCW'(1);
      2'b01:   occ_d = occ_q - OCW'(1);
      default: occ_d = occ_q;
    endcase
    word_valid_d = (occ_d != '0);
    word_out_d   = word_valid_d ? mem_d[rd_ptr_d] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      bcnt_q      <= '0;
      shreg_q     <= '0;
      pend_q      <= 1'b0;
      pend_word_q <= '0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      shreg_q     <= shreg_d;
      pend_q      <= pend_d;
      pend_word_q <= pend_word_d;
      sync_err_q  <= sync_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
      frame_cnt_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
      frame_cnt_q  <= frame_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
  assign frame_cnt  = frame_cnt_q;
  assign overflow   = overflow_q;
  assign sync_err   = sync_err_q;

endmodule
